// File: rtl/maxpool2x2_stream_if.sv
// Handshake bundle for maxpool2x2_stream: pixel input side and pooled output side.
// slave = pooling stage, master = upstream producer / downstream consumer.
interface maxpool2x2_stream_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2/stride-2 signed max-pool over a raster WxH map; result registered 1 cycle after the window's last pixel.
// Backpressure: single output register; in_ready drops only while a pooled pixel is pending and not taken.
module maxpool2x2_stream #(
  parameter int W          = 24,
  parameter int H          = 24,
  parameter int DATA_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  maxpool2x2_stream_if.slave   io_bus
);
  localparam int HW = W / 2;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam int LW = (HW > 1) ? $clog2(HW) : 1;

  typedef logic signed [DATA_WIDTH-1:0] px_t;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  px_t           r_pair;
  px_t           r_lbuf [HW];
  px_t           r_out_data;
  logic          r_out_valid;
  logic          r_out_last;

  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_win_done;
  logic [LW-1:0] w_lb_idx;
  px_t           w_pix;
  px_t           w_pair_max;
  px_t           w_win_max;

  assign w_pix      = px_t'(io_bus.in_data);
  assign w_in_fire  = io_bus.in_valid && io_bus.in_ready;
  assign w_out_fire = r_out_valid && io_bus.out_ready;
  assign w_col_last = (r_col == CW'(W - 1));
  assign w_row_last = (r_row == RW'(H - 1));
  assign w_win_done = w_in_fire && r_col[0] && r_row[0];
  assign w_lb_idx   = LW'(r_col >> 1);

  // Horizontal pair max, then combined with the partial max saved from the row above.
  assign w_pair_max = (w_pix > r_pair) ? w_pix : r_pair;
  assign w_win_max  = (r_lbuf[w_lb_idx] > w_pair_max) ? r_lbuf[w_lb_idx] : w_pair_max;

  assign io_bus.in_ready  = !r_out_valid || io_bus.out_ready;
  assign io_bus.out_data  = r_out_data;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_last  = r_out_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_pair      <= '0;
      for (int i = 0; i < HW; i++) begin
        r_lbuf[i] <= '0;
      end
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_in_fire) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end

        if (!r_col[0]) begin
          r_pair <= w_pix;
        end else if (!r_row[0]) begin
          r_lbuf[w_lb_idx] <= w_pair_max;
        end
      end

      // A new result wins over clearing: the old one is being taken this same cycle.
      if (w_win_done) begin
        r_out_data  <= w_win_max;
        r_out_valid <= 1'b1;
        r_out_last  <= w_col_last && w_row_last;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule
